ofmap_spike_packetizer: RTL

Clocked output stage of a PE: collects fired output spikes (ofmap row/col) produced by the PE's accumulate/threshold logic and turns them into 64-bit NoC packets of type output, addressed to the memory interface node. Buffers spikes in a small FIFO, keeps spike/DONE ordering, and closes every timestep with one DONE packet. The memory interface counts these DONEs to advance its timestep.

---
 rtl/ofmap_spike_packetizer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ofmap_spike_packetizer.sv
// PE output stage: buffers fired ofmap spikes and emits 64-bit NoC output packets, closing each timestep with a DONE packet.
// Optional build macro OFMAP_PKT_STATS_EN adds pkt_count / drop_count statistics ports.
module ofmap_spike_packetizer #(
  parameter logic [3:0]  SRC_ADDR   = 4'b0001,
  parameter logic [3:0]  DEST_ADDR  = 4'b0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OFMAP_DIM  = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spk_valid,
  output logic        spk_ready,
  input  logic [4:0]  spk_row,
  input  logic [4:0]  spk_col,
  input  logic        spk_fire,
  input  logic        ts_done_valid,
  output logic        ts_done_ready,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [63:0] pkt_data
`ifdef OFMAP_PKT_STATS_EN
  ,
  output logic [15:0] pkt_count,
  output logic [7:0]  drop_count
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [1:0] PKT_TYPE = 2'b11;
  localparam logic [9:0] DONE_CODE = 10'h1FF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    DRAIN     = 2'd2,
    SEND_DONE = 2'd3
  } fsmStateT;

  logic [9:0]    fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] fifoCount;
  logic [CW-1:0] countNext;
  logic          donePending;
  logic          donePendingNext;
  fsmStateT      state;
  fsmStateT      stateNext;

  logic fifoNonEmpty;
  logic fifoFull;
  logic inRange;
  logic spkAccept;
  logic doneAccept;
  logic push;
  logic pop;
  logic oregFree;
  logic doneLoad;

  // STREAM/DRAIN are exactly the FIFO-non-empty states
  assign fifoNonEmpty  = (state == STREAM) || (state == DRAIN);
  assign fifoFull      = (fifoCount == CW'(FIFO_DEPTH));
  assign spk_ready     = !fifoFull && !donePending;
  assign ts_done_ready = !donePending;

  assign inRange    = (32'(spk_row) < OFMAP_DIM) && (32'(spk_col) < OFMAP_DIM);
  assign spkAccept  = spk_valid && spk_ready;
  assign push       = spkAccept && spk_fire && inRange;
  assign doneAccept = ts_done_valid && ts_done_ready;
  assign oregFree   = !pkt_valid || pkt_ready;
  assign pop        = oregFree && fifoNonEmpty;
  assign doneLoad   = oregFree && !fifoNonEmpty && donePending;

  // Next-state values shared by the register block
  always_comb begin
    countNext       = fifoCount + CW'(push) - CW'(pop);
    donePendingNext = (donePending && !doneLoad) || doneAccept;
    stateNext       = IDLE;
    if (countNext != '0) begin
      stateNext = donePendingNext ? DRAIN : STREAM;
    end else if (doneLoad || donePendingNext ||
                 ((state == SEND_DONE) && pkt_valid && !pkt_ready)) begin
      stateNext = SEND_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= {spk_row, spk_col};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      donePending <= 1'b0;
      state       <= IDLE;
      pkt_valid   <= 1'b0;
      pkt_data    <= '0;
    end else begin
      fifoCount   <= countNext;
      donePending <= donePendingNext;
      state       <= stateNext;
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      // Output register: FIFO head beats DONE so spikes stay ahead of their timestep's DONE
      if (pop) begin
        pkt_valid <= 1'b1;
        pkt_data  <= {DEST_ADDR, SRC_ADDR, PKT_TYPE, 44'd0, fifoMem[rdPtr]};
      end else if (doneLoad) begin
        pkt_valid <= 1'b1;
        pkt_data  <= {DEST_ADDR, SRC_ADDR, PKT_TYPE, 44'd0, DONE_CODE};
      end else if (oregFree) begin
        pkt_valid <= 1'b0;
      end
    end
  end

`ifdef OFMAP_PKT_STATS_EN
  // Delivered packets wrap; out-of-range drops saturate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (pkt_valid && pkt_ready) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (spkAccept && spk_fire && !inRange && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end
`endif

endmodule
